sram_wrap_l1_pipe: RTL

//  Parametrised successor to the fixed L1 SRAM wrapper: single-port, byte-masked, behavioural SRAM with

---
 rtl/sram_wrap_l1_pipe_if.sv | 30 +++
 rtl/sram_wrap_l1_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sram_wrap_l1_pipe_if.sv
// Request/response bundle between L1 cache control (master) and the SRAM wrapper (slave).
interface sram_wrap_l1_pipe_if #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 11,
  parameter int RSP_DEPTH = 8
);
  localparam int OW = $clog2(RSP_DEPTH + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  init_done;
  logic [OW-1:0]         rd_outstanding;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done, rd_outstanding
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done, rd_outstanding
  );
endinterface

// File: rtl/sram_wrap_l1_pipe.sv
// Single-port byte-masked SRAM with a fixed-latency read pipe, a credit-limited
// in-order response FIFO (registered show-ahead head) and an optional zero sweep.
module sram_wrap_l1_pipe #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 6,
  parameter int RSP_DEPTH = 8,
  parameter int INIT_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_wrap_l1_pipe_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int MAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OW     = $clog2(RSP_DEPTH + 1);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [MAW-1:0]  LAST_IDX = MAW'(DEPTH - 1);
  localparam logic [OW-1:0]   CREDITS  = OW'(RSP_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(RSP_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Byte-lane merge of new data into an existing word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MASK_W; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Circular pointer advance for a FIFO whose depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  state_t              state_q, state_d;
  logic [MAW-1:0]      init_cnt_q, init_cnt_d;
  logic                sweep_we;
  logic                init_done_q;
  logic                req_ready_q, req_ready_d;
  logic [OW-1:0]       outst_q, outst_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range;
  logic [MAW-1:0]      req_idx;
  logic                acc, wr_acc, rd_acc;
  logic [DATA_W-1:0]   rd_word;

  logic [READ_LAT-1:0] pipe_vld_q;
  logic [DATA_W-1:0]   pipe_data_q [READ_LAT];

  logic [DATA_W-1:0]   buf_q [RSP_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]       cnt_q, cnt_d, old_left;
  logic                push, pop;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  assign in_range = ({1'b0, bus.req_addr} < DEPTH_C);
  assign req_idx  = bus.req_addr[MAW-1:0];
  // Accepts are suppressed on a reset edge so that reset never disturbs the array.
  assign acc      = bus.req_valid & req_ready_q & ~rst;
  assign wr_acc   = acc & bus.req_we & in_range;
  assign rd_acc   = acc & ~bus.req_we;
  assign rd_word  = in_range ? mem_q[req_idx] : '0;

  assign push = pipe_vld_q[READ_LAT-1];
  assign pop  = rsp_valid_q & bus.rsp_ready;

  // FSM state register: reset always restarts the init phase.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // FSM next state: leave INIT after the last swept word (or at once without a sweep).
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT) begin
      if ((INIT_ZERO == 0) || (init_cnt_q == LAST_IDX)) state_d = ST_RUN;
    end
  end

  // FSM outputs: sweep write strobe and sweep address advance.
  always_comb begin
    sweep_we   = (state_q == ST_INIT) && (INIT_ZERO != 0);
    init_cnt_d = sweep_we ? init_cnt_q + MAW'(1) : init_cnt_q;
  end

  // Array write port, shared by the init sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (sweep_we && !rst) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[req_idx] <= merge_bytes(mem_q[req_idx], bus.req_wdata, bus.req_wmask);
    end
  end

  // Read pipe data: stage 0 samples the array at accept, later stages just delay it.
  always_ff @(posedge clk) begin
    // ---- stage 0: array sample ----
    if (rd_acc) pipe_data_q[0] <= rd_word;
    // ---- stages 1..READ_LAT-1: delay line into the response FIFO ----
    for (int i = 1; i < READ_LAT; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  // Response FIFO storage; the pipe tail is written at the tail pointer.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= pipe_data_q[READ_LAT-1];
  end

  // Next FIFO/credit state and the next registered head word.
  always_comb begin
    cnt_d    = cnt_q + OW'(push) - OW'(pop);
    outst_d  = outst_q + OW'(rd_acc) - OW'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    old_left = cnt_q - OW'(pop);
    rsp_rdata_d = rsp_rdata_q;
    // With older entries left the head comes from storage; an empty FIFO
    // bypasses the arriving word straight into the head register.
    if (old_left != '0) rsp_rdata_d = buf_q[rd_ptr_d];
    else if (push)      rsp_rdata_d = pipe_data_q[READ_LAT-1];
    rsp_valid_d = (cnt_d != '0);
    req_ready_d = (state_d == ST_RUN) && (outst_d < CREDITS);
  end

  // Control registers: sweep counter, credits, pipe valids, FIFO pointers and head.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      req_ready_q <= 1'b0;
      outst_q     <= '0;
      pipe_vld_q  <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_RUN);
      req_ready_q <= req_ready_d;
      outst_q     <= outst_d;
      pipe_vld_q[0] <= rd_acc;
      for (int i = 1; i < READ_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.init_done      = init_done_q;
  assign bus.rd_outstanding = outst_q;
endmodule
